bdpsk_demod: RTL and testbench

BDPSK_DEMOD -- requirements
Module: bdpsk_demod

---
 rtl/bdpsk_demod.sv | 166 ++++++++++++++++
 tb/tb_bdpsk_demod.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bdpsk_demod.sv
// Binary differential PSK demodulator with a PN7 (x^7 + x^6 + 1) bit-error checker.
// Integrate-and-dump correlation against a square carrier, then differential decode and PN lock tracking.
module bdpsk_demod #(
  parameter int SPS    = 128,
  parameter int LOCK_N = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  adc_data,
  input  logic        adc_valid,
  input  logic        sym_align,
  output logic        bit_out,
  output logic        bit_valid,
  output logic        pn_lock,
  output logic [15:0] err_cnt,
  output logic [1:0]  pn_state
);

  localparam int KW = $clog2(SPS);
  localparam int AW = 8 + KW + 1;
  localparam int CW = $clog2(LOCK_N + 8);

  // Handshake: adc_valid qualifies adc_data for exactly one cycle and there is no
  // ready; every qualified sample is consumed. bit_valid is a one-cycle strobe
  // that marks bit_out as new; the consumer cannot stall it.

  logic [KW-1:0]        k;
  logic [KW-1:0]        k_eff;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] s_ext;
  logic signed [AW-1:0] ws;
  logic signed [AW-1:0] acc_sum;
  logic                 raw;
  logic                 raw_prev;
  logic                 first_sym;

  // A sample arriving with sym_align is sample 0 of a fresh symbol.
  always_comb begin
    s_ext   = {{(AW-8){~adc_data[7]}}, ~adc_data[7], adc_data[6:0]};
    k_eff   = sym_align ? '0 : k;
    ws      = k_eff[KW-1] ? -s_ext : s_ext;
    acc_sum = (sym_align ? '0 : acc) + ws;
    raw     = acc_sum[AW-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k         <= '0;
      acc       <= '0;
      raw_prev  <= 1'b0;
      first_sym <= 1'b1;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
    end else begin
      bit_valid <= 1'b0;
      if (sym_align) begin
        k         <= '0;
        acc       <= '0;
        first_sym <= 1'b1;
      end
      if (adc_valid) begin
        if (k_eff == KW'(SPS - 1)) begin
          k        <= '0;
          acc      <= '0;
          raw_prev <= raw;
          if (first_sym) begin
            first_sym <= 1'b0;
          end else begin
            bit_out   <= raw ^ raw_prev;
            bit_valid <= 1'b1;
          end
        end else begin
          k   <= k_eff + KW'(1);
          acc <= acc_sum;
        end
      end
    end
  end

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    CHECK = 2'd1,
    LOCK  = 2'd2
  } pn_state_t;

  pn_state_t     state;
  logic [6:0]    lfsr;
  logic [CW-1:0] cnt;
  logic [5:0]    win_cnt;
  logic [3:0]    win_err;
  logic [3:0]    win_err_nxt;
  logic          predicted;
  logic          mismatch;

  always_comb begin
    predicted   = lfsr[6] ^ lfsr[5];
    mismatch    = bit_out ^ predicted;
    win_err_nxt = win_err + {3'b000, mismatch};
  end

  // cnt counts loaded bits in HUNT and consecutive matches in CHECK.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= HUNT;
      lfsr    <= '0;
      cnt     <= '0;
      win_cnt <= '0;
      win_err <= '0;
      pn_lock <= 1'b0;
      err_cnt <= '0;
    end else if (state != HUNT && lfsr == 7'd0) begin
      state   <= HUNT;
      cnt     <= '0;
      pn_lock <= 1'b0;
    end else if (bit_valid) begin
      case (state)
        HUNT: begin
          lfsr <= {lfsr[5:0], bit_out};
          if (cnt == CW'(6)) begin
            state <= CHECK;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        CHECK: begin
          lfsr <= {lfsr[5:0], bit_out};
          if (mismatch) begin
            state <= HUNT;
            cnt   <= '0;
          end else if (cnt == CW'(LOCK_N - 1)) begin
            state   <= LOCK;
            pn_lock <= 1'b1;
            win_cnt <= '0;
            win_err <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        LOCK: begin
          // Flywheel: the reference keeps running from its own prediction.
          lfsr <= {lfsr[5:0], predicted};
          if (mismatch && err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'd1;
          end
          if (win_err_nxt >= 4'd8) begin
            state   <= HUNT;
            cnt     <= '0;
            pn_lock <= 1'b0;
          end else begin
            win_cnt <= win_cnt + 6'd1;
            win_err <= (win_cnt == 6'd63) ? 4'd0 : win_err_nxt;
          end
        end
        default: begin
          state   <= HUNT;
          cnt     <= '0;
          pn_lock <= 1'b0;
        end
      endcase
    end
  end

  assign pn_state = state;

endmodule

// File: tb/tb_bdpsk_demod.sv
// Self-checking bench for bdpsk_demod: directed steps plus randomized symbols checked
// against a per-symbol correlation model and PN7 lock expectations.
module tb_bdpsk_demod;

  localparam int SPS    = 128;
  localparam int LOCK_N = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  adc_data;
  logic        adc_valid;
  logic        sym_align;
  logic        bit_out;
  logic        bit_valid;
  logic        pn_lock;
  logic [15:0] err_cnt;
  logic [1:0]  pn_state;

  always #5 clk = ~clk;

  bdpsk_demod #(.SPS(SPS), .LOCK_N(LOCK_N)) dut (
    .clk       (clk),
    .reset     (reset),
    .adc_data  (adc_data),
    .adc_valid (adc_valid),
    .sym_align (sym_align),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .pn_lock   (pn_lock),
    .err_cnt   (err_cnt),
    .pn_state  (pn_state)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bits_seen = 0;
  logic last_bit = 1'b0;

  logic [0:0] exp_q[$];
  int         exp_cyc_q[$];

  int sym_buf[$];
  bit m_first = 1'b1;
  bit m_prev  = 1'b0;

  logic [6:0] pn_reg;
  bit         tx_raw;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a symbol's decision is the sign of (sum of first-half centred samples
  // minus sum of second-half centred samples); decoded bit is the XOR with the previous decision.
  task automatic model_symbol(input int at_cyc);
    int total;
    bit r;
    total = 0;
    for (int i = 0; i < SPS; i++) total += (i < SPS/2) ? sym_buf[i] : -sym_buf[i];
    r = (total < 0);
    sym_buf.delete();
    if (m_first) begin
      m_first = 1'b0;
    end else begin
      exp_q.push_back(r ^ m_prev);
      exp_cyc_q.push_back(at_cyc);
    end
    m_prev = r;
  endtask

  always @(negedge clk) begin
    if (bit_valid === 1'b1) begin
      bits_seen++;
      last_bit = bit_out;
      if (exp_q.size() == 0) begin
        check("unexpected_bit_valid", 32'd1, 32'd0);
      end else begin
        check("bit_out", {31'd0, bit_out}, {31'd0, exp_q.pop_front()});
        check("bit_valid_cycle", cyc, exp_cyc_q.pop_front());
      end
    end
  end

  task automatic drive(input bit v, input logic [7:0] d, input bit al);
    @(negedge clk);
    adc_valid = v;
    adc_data  = d;
    sym_align = al;
    if (al) begin
      sym_buf.delete();
      m_first = 1'b1;
    end
    if (v) begin
      sym_buf.push_back(int'(d) - 128);
      if (sym_buf.size() == SPS) model_symbol(cyc + 1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    adc_valid = 1'b0;
    sym_align = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    sym_buf.delete();
    m_first = 1'b1;
    m_prev  = 1'b0;
  endtask

  // flip=0: first half high. Two idle cycles follow so the bit and the PN update are visible.
  task automatic send_symbol(input bit flip, input int amp, input int noise,
                             input int gap_pct, input int align_at);
    for (int i = 0; i < SPS; i++) begin
      int x;
      bit hi;
      hi = (i < SPS/2) ^ flip;
      x  = hi ? 128 + amp : 128 - amp;
      if (noise > 0) x += int'($urandom_range(2 * noise)) - noise;
      if (x < 0) x = 0;
      if (x > 255) x = 255;
      if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) drive(1'b0, 8'($urandom), 1'b0);
      drive(1'b1, 8'(x), i == align_at);
    end
    drive(1'b0, 8'h80, 1'b0);
    drive(1'b0, 8'h80, 1'b0);
  endtask

  task automatic pn_bit(input bit flip);
    bit b;
    b      = pn_reg[6] ^ pn_reg[5];
    pn_reg = {pn_reg[5:0], b};
    tx_raw = tx_raw ^ b ^ flip;
    send_symbol(tx_raw, 72, 0, 0, -1);
  endtask

  initial begin
    int base;
    reset     = 1'b1;
    adc_valid = 1'b0;
    adc_data  = 8'h80;
    sym_align = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_bit_out", {31'd0, bit_out}, 32'd0);
    check("reset_bit_valid", {31'd0, bit_valid}, 32'd0);
    check("reset_pn_lock", {31'd0, pn_lock}, 32'd0);
    check("reset_err_cnt", {16'd0, err_cnt}, 32'd0);
    check("reset_state", {30'd0, pn_state}, 32'd0);
    reset = 1'b0;

    // Three unflipped symbols: two bits, both zero.
    repeat (3) send_symbol(1'b0, 72, 0, 0, -1);
    check("steady_bit_count", bits_seen, 2);
    check("steady_last_bit", {31'd0, last_bit}, 32'd0);

    // Phase flip on the third symbol.
    do_reset();
    base = bits_seen;
    send_symbol(1'b0, 72, 0, 0, -1);
    send_symbol(1'b0, 72, 0, 0, -1);
    send_symbol(1'b1, 72, 0, 0, -1);
    check("flip_bit", {31'd0, last_bit}, 32'd1);
    send_symbol(1'b0, 72, 0, 0, -1);
    check("unflip_bit", {31'd0, last_bit}, 32'd1);
    send_symbol(1'b0, 72, 0, 0, -1);
    check("steady_after_flip", {31'd0, last_bit}, 32'd0);
    check("flip_bit_count", bits_seen - base, 4);

    // Randomized symbols with noise, gaps and occasional mid-symbol realignment.
    for (int n = 0; n < 40; n++) begin
      int al;
      al = ($urandom_range(9) == 0) ? int'($urandom_range(SPS - 1)) : -1;
      send_symbol(1'($urandom_range(1)), int'($urandom_range(100, 5)), 30, 20, al);
    end

    // sym_align together with the sample at k = 70.
    do_reset();
    send_symbol(1'b0, 72, 0, 0, -1);
    send_symbol(1'b1, 72, 0, 0, -1);
    base = bits_seen;
    send_symbol(1'b0, 72, 0, 0, 70);
    check("align_no_bit_58", bits_seen - base, 0);
    send_symbol(1'b0, 72, 0, 0, -1);
    check("align_first_symbol_silent", bits_seen - base, 0);
    send_symbol(1'b0, 72, 0, 0, -1);
    check("align_second_symbol_bit", bits_seen - base, 1);

    // PN7 lock acquisition.
    do_reset();
    pn_reg = 7'h7F;
    tx_raw = 1'b0;
    send_symbol(1'b0, 72, 0, 0, -1);
    for (int n = 0; n < 7; n++) pn_bit(1'b0);
    check("pn_check_after_7", {30'd0, pn_state}, 32'd1);
    for (int n = 0; n < LOCK_N - 1; n++) pn_bit(1'b0);
    check("pn_unlocked_before_last", {31'd0, pn_lock}, 32'd0);
    pn_bit(1'b0);
    check("pn_locked", {31'd0, pn_lock}, 32'd1);
    check("pn_lock_state", {30'd0, pn_state}, 32'd2);
    check("pn_err_zero", {16'd0, err_cnt}, 32'd0);

    // Single error, then eight in the same 64-bit window.
    pn_bit(1'b0);
    pn_bit(1'b0);
    pn_bit(1'b1);
    check("one_err_cnt", {16'd0, err_cnt}, 32'd1);
    check("one_err_lock", {31'd0, pn_lock}, 32'd1);
    pn_bit(1'b0);
    pn_bit(1'b0);
    for (int n = 0; n < 6; n++) pn_bit(1'b1);
    check("seven_err_cnt", {16'd0, err_cnt}, 32'd7);
    check("seven_err_lock", {31'd0, pn_lock}, 32'd1);
    pn_bit(1'b1);
    check("eight_err_unlock", {31'd0, pn_lock}, 32'd0);
    check("eight_err_hunt", {30'd0, pn_state}, 32'd0);
    check("eight_err_cnt", {16'd0, err_cnt}, 32'd8);

    // Reacquire, then saturate the error counter.
    for (int n = 0; n < 7 + LOCK_N; n++) pn_bit(1'b0);
    check("relock", {31'd0, pn_lock}, 32'd1);
    check("relock_err_kept", {16'd0, err_cnt}, 32'd8);
    force dut.err_cnt = 16'hFFFF;
    drive(1'b0, 8'h80, 1'b0);
    release dut.err_cnt;
    drive(1'b0, 8'h80, 1'b0);
    pn_bit(1'b1);
    check("err_saturated", {16'd0, err_cnt}, 32'd65535);
    check("sat_still_locked", {31'd0, pn_lock}, 32'd1);

    // Reset mid-symbol while locked.
    for (int n = 0; n < 60; n++) drive(1'b1, 8'd200, 1'b0);
    do_reset();
    check("midreset_bit_out", {31'd0, bit_out}, 32'd0);
    check("midreset_bit_valid", {31'd0, bit_valid}, 32'd0);
    check("midreset_pn_lock", {31'd0, pn_lock}, 32'd0);
    check("midreset_err_cnt", {16'd0, err_cnt}, 32'd0);
    check("midreset_state", {30'd0, pn_state}, 32'd0);
    base = bits_seen;
    send_symbol(1'b1, 72, 0, 0, -1);
    send_symbol(1'b1, 72, 0, 0, -1);
    check("post_reset_first_silent", bits_seen - base, 1);
    check("post_reset_bit", {31'd0, last_bit}, 32'd0);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
